// File: rtl/relais_bank.sv
// relais_bank: a bank of CH independent debounced relay channels.
// Each channel compares a signed control sample against a common threshold
// pair (VT +/- VH). LATCH selects the channel behaviour:
//   LATCH = 0: hysteresis relay.
//   LATCH = 1: toggle relay, advanced by rising crossings of TH_HI.
// A channel changes contact only after DEB consecutive qualifying valid
// samples. A per-channel force input overrides the debounce logic.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; release is taken synchronously
//   in_valid   in_data carries a new sample set this cycle
//   in_data    CH x W two's-complement samples; channel k is at [k*W +: W]
//   force_en   per-channel override request
//   force_val  per-channel override contact value (1 = closed)
//   closed     registered contact state per channel
//   change     one-cycle pulse in the cycle closed[k] takes a new value
//   busy       registered OR of "channel is mid-debounce" over all channels
module relais_bank #(
    parameter int CH    = 4,
    parameter int W     = 12,
    parameter int VT    = 0,
    parameter int VH    = 64,
    parameter int DEB   = 4,
    parameter int LATCH = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [CH*W-1:0] in_data,
    input  logic [CH-1:0]   force_en,
    input  logic [CH-1:0]   force_val,
    output logic [CH-1:0]   closed,
    output logic [CH-1:0]   change,
    output logic            busy
);

    localparam int CW = $clog2(DEB + 1);
    localparam logic [CW-1:0] DEB_M1 = CW'(DEB - 1);

    // Thresholds carry one extra bit so that VT +/- VH cannot wrap for any
    // in-range W-bit threshold code.
    localparam logic signed [W:0] TH_HI = (W+1)'(VT + VH);
    localparam logic signed [W:0] TH_LO = (W+1)'(VT - VH);

    typedef enum logic [1:0] {
        OPEN       = 2'd0,
        PEND_CLOSE = 2'd1,
        CLOSED     = 2'd2,
        PEND_OPEN  = 2'd3
    } state_t;

    logic [CH-1:0] pend_nxt;

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic signed [W:0] smp;
        logic              above;
        logic              under;
        logic              q_close;
        logic              q_open;
        state_t            st;
        state_t            st_nxt;
        logic [CW-1:0]     cnt;
        logic [CW-1:0]     cnt_nxt;
        // Edge history: 1 when the last valid sample was at or below TH_HI.
        logic              hist;
        logic              hist_nxt;
        logic              closed_q;
        logic              change_q;
        logic              closed_nxt;

        assign smp   = {in_data[k*W + W - 1], in_data[k*W +: W]};
        assign above = smp > TH_HI;
        assign under = smp < TH_LO;

        // In toggle mode a debounce run may only start on a rising crossing.
        // Once pending, every further sample above TH_HI keeps the run going.
        assign q_close = (LATCH != 0) ? (above && (hist || st == PEND_CLOSE)) : above;
        assign q_open  = (LATCH != 0) ? (above && (hist || st == PEND_OPEN))  : under;

        always_comb begin
            st_nxt   = st;
            cnt_nxt  = cnt;
            hist_nxt = hist;
            if (in_valid) begin
                hist_nxt = !above;
            end
            if (force_en[k]) begin
                st_nxt  = force_val[k] ? CLOSED : OPEN;
                cnt_nxt = '0;
            end else if (in_valid) begin
                // cnt is 0 in the stable states, so "cnt == DEB-1" also
                // covers DEB = 1 switching directly from a stable state.
                unique case (st)
                    OPEN, PEND_CLOSE: begin
                        if (q_close) begin
                            if (cnt == DEB_M1) begin
                                st_nxt  = CLOSED;
                                cnt_nxt = '0;
                            end else begin
                                st_nxt  = PEND_CLOSE;
                                cnt_nxt = cnt + 1'b1;
                            end
                        end else begin
                            st_nxt  = OPEN;
                            cnt_nxt = '0;
                        end
                    end
                    CLOSED, PEND_OPEN: begin
                        if (q_open) begin
                            if (cnt == DEB_M1) begin
                                st_nxt  = OPEN;
                                cnt_nxt = '0;
                            end else begin
                                st_nxt  = PEND_OPEN;
                                cnt_nxt = cnt + 1'b1;
                            end
                        end else begin
                            st_nxt  = CLOSED;
                            cnt_nxt = '0;
                        end
                    end
                    default: begin
                        st_nxt  = OPEN;
                        cnt_nxt = '0;
                    end
                endcase
            end
        end

        assign closed_nxt  = (st_nxt == CLOSED) || (st_nxt == PEND_OPEN);
        assign pend_nxt[k] = (st_nxt == PEND_CLOSE) || (st_nxt == PEND_OPEN);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st       <= OPEN;
                cnt      <= '0;
                hist     <= 1'b1;
                closed_q <= 1'b0;
                change_q <= 1'b0;
            end else begin
                st       <= st_nxt;
                cnt      <= cnt_nxt;
                hist     <= hist_nxt;
                closed_q <= closed_nxt;
                change_q <= closed_nxt ^ closed_q;
            end
        end

        assign closed[k] = closed_q;
        assign change[k] = change_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
        end else begin
            busy <= |pend_nxt;
        end
    end

endmodule

// File: tb/tb_relais_bank.sv
// Bench for relais_bank: three instances sharing one stimulus stream.
//   u0: defaults (hysteresis, DEB=4, VT=0, VH=64)
//   u1: VT=2047 (TH_HI beyond the W-bit sample range)
//   u2: LATCH=1, DEB=2 (toggle relay)
// A per-channel contact/run-length model predicts every output each cycle.
// Literal expectations pin the model at the interesting points.
module tb_relais_bank;
    localparam int CH = 4;
    localparam int W  = 12;
    localparam int NI = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            in_valid = 1'b0;
    logic [CH*W-1:0] in_data = '0;
    logic [CH-1:0]   force_en = '0;
    logic [CH-1:0]   force_val = '0;
    logic [CH-1:0]   cl [NI];
    logic [CH-1:0]   cg [NI];
    logic            bz [NI];

    int cmp_cnt = 0;
    int err_cnt = 0;
    bit chk_on = 1'b0;
    int smp [CH];

    int p_hi    [NI] = '{64, 2111, 64};
    int p_lo    [NI] = '{-64, 1983, -64};
    int p_deb   [NI] = '{4, 4, 2};
    int p_latch [NI] = '{0, 0, 1};

    bit m_con [NI][CH];
    int m_run [NI][CH];
    bit m_blw [NI][CH];
    bit m_chg [NI][CH];

    relais_bank u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
                    .force_en(force_en), .force_val(force_val),
                    .closed(cl[0]), .change(cg[0]), .busy(bz[0]));
    relais_bank #(.VT(2047)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
                    .force_en(force_en), .force_val(force_val),
                    .closed(cl[1]), .change(cg[1]), .busy(bz[1]));
    relais_bank #(.DEB(2), .LATCH(1)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
                    .force_en(force_en), .force_val(force_val),
                    .closed(cl[2]), .change(cg[2]), .busy(bz[2]));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        cmp_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < CH; k++) begin
                m_con[i][k] = 1'b0;
                m_run[i][k] = 0;
                m_blw[i][k] = 1'b1;
                m_chg[i][k] = 1'b0;
            end
        end
    endtask

    // Contact flips after p_deb consecutive samples pushing it the other way.
    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < CH; k++) begin
                bit old;
                bit q;
                old = m_con[i][k];
                q = 1'b0;
                if (force_en[k]) begin
                    m_con[i][k] = force_val[k];
                    m_run[i][k] = 0;
                end else if (in_valid) begin
                    if (p_latch[i] != 0)
                        q = (smp[k] > p_hi[i]) && (m_run[i][k] > 0 || m_blw[i][k]);
                    else
                        q = m_con[i][k] ? (smp[k] < p_lo[i]) : (smp[k] > p_hi[i]);
                    if (q) begin
                        m_run[i][k]++;
                        if (m_run[i][k] >= p_deb[i]) begin
                            m_con[i][k] = !m_con[i][k];
                            m_run[i][k] = 0;
                        end
                    end else begin
                        m_run[i][k] = 0;
                    end
                end
                if (in_valid) m_blw[i][k] = (smp[k] <= p_hi[i]);
                m_chg[i][k] = (m_con[i][k] != old);
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < NI; i++) begin
                logic [CH-1:0] ec;
                logic [CH-1:0] eg;
                logic          eb;
                eb = 1'b0;
                for (int k = 0; k < CH; k++) begin
                    ec[k] = m_con[i][k];
                    eg[k] = m_chg[i][k];
                    if (m_run[i][k] > 0) eb = 1'b1;
                end
                chk($sformatf("u%0d.closed", i), int'(cl[i]), int'(ec));
                chk($sformatf("u%0d.change", i), int'(cg[i]), int'(eg));
                chk($sformatf("u%0d.busy", i), int'(bz[i]), int'(eb));
            end
        end
    end

    // One clock cycle: drive after the falling edge, update the model at the
    // rising edge, return just after the next falling edge.
    task automatic cyc(input bit v, input int s0, input int s1, input int s2, input int s3,
                       input logic [CH-1:0] fe, input logic [CH-1:0] fv);
        in_valid = v;
        smp[0] = s0; smp[1] = s1; smp[2] = s2; smp[3] = s3;
        for (int k = 0; k < CH; k++) in_data[k*W +: W] = smp[k][W-1:0];
        force_en  = fe;
        force_val = fv;
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic vs(input int s0, input int s1, input int s2, input int s3);
        cyc(1'b1, s0, s1, s2, s3, 4'b0000, 4'b0000);
    endtask

    task automatic gap();
        cyc(1'b0, 500, 500, 500, 500, 4'b0000, 4'b0000);
    endtask

    // Assert reset between clock edges; outputs must drop without a clock.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s.u%0d.closed", tag, i), int'(cl[i]), 0);
            chk($sformatf("%s.u%0d.change", tag, i), int'(cg[i]), 0);
            chk($sformatf("%s.u%0d.busy", tag, i), int'(bz[i]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        for (int k = 0; k < CH; k++) smp[k] = 0;
        model_reset();
        #1;
        do_reset("rst0");
        chk_on = 1'b1;

        // Close ch0 with four samples of 100
        vs(100, 0, 0, 0);
        vs(100, 0, 0, 0);
        vs(100, 0, 0, 0);
        chk("a.busy3", int'(bz[0]), 1);
        chk("a.closed3", int'(cl[0][0]), 0);
        vs(100, 0, 0, 0);
        chk("a.closed4", int'(cl[0][0]), 1);
        chk("a.change4", int'(cg[0][0]), 1);
        chk("a.busy4", int'(bz[0]), 0);
        gap();
        chk("a.change_gap", int'(cg[0][0]), 0);

        // Inside-band samples hold the contact; -65 opens it
        for (int n = 0; n < 6; n++) vs(-30, 0, 0, 0);
        chk("b.hold", int'(cl[0][0]), 1);
        for (int n = 0; n < 3; n++) vs(-65, 0, 0, 0);
        chk("b.open3", int'(cl[0][0]), 1);
        vs(-65, 0, 0, 0);
        chk("b.open4", int'(cl[0][0]), 0);
        chk("b.change", int'(cg[0][0]), 1);

        // Interrupted run on ch1 restarts the count
        vs(0, 100, 0, 0); vs(0, 100, 0, 0); vs(0, 100, 0, 0); vs(0, 0, 0, 0); vs(0, 100, 0, 0);
        chk("c.noclose", int'(cl[0][1]), 0);
        vs(0, 100, 0, 0); vs(0, 100, 0, 0);
        chk("c.still_open", int'(cl[0][1]), 0);
        vs(0, 100, 0, 0);
        chk("c.closed", int'(cl[0][1]), 1);
        for (int n = 0; n < 4; n++) vs(0, -100, 0, 0);
        chk("c.reopen", int'(cl[0][1]), 0);
        // Same pattern with invalid cycles in between
        vs(0, 100, 0, 0); gap(); vs(0, 100, 0, 0); gap(); gap(); vs(0, 100, 0, 0); gap();
        vs(0, 0, 0, 0); gap(); vs(0, 100, 0, 0); gap();
        vs(0, 100, 0, 0); gap(); vs(0, 100, 0, 0); gap();
        chk("c.gap_open", int'(cl[0][1]), 0);
        vs(0, 100, 0, 0);
        chk("c.gap_closed", int'(cl[0][1]), 1);
        for (int n = 0; n < 4; n++) vs(0, -100, 0, 0);

        // Threshold equality and top-of-range samples
        for (int n = 0; n < 10; n++) vs(0, 0, 64, 2047);
        chk("d.eq_th", int'(cl[0][2]), 0);
        chk("d.u0_2047", int'(cl[0][3]), 1);
        chk("d.u1_nowrap", int'(cl[1]), 0);

        // Force ch2 closed while pending
        vs(0, 0, 100, 2047); vs(0, 0, 100, 2047);
        chk("e.pend", int'(bz[0]), 1);
        cyc(1'b1, 0, 0, 100, 2047, 4'b0100, 4'b0100);
        chk("e.forced", int'(cl[0][2]), 1);
        chk("e.forced_chg", int'(cg[0][2]), 1);
        chk("e.forced_busy", int'(bz[0]), 0);
        for (int n = 0; n < 3; n++) cyc(1'b1, 0, 0, -100, 2047, 4'b0100, 4'b0100);
        chk("e.pinned", int'(cl[0][2]), 1);
        chk("e.pinned_chg", int'(cg[0][2]), 0);
        for (int n = 0; n < 3; n++) vs(0, 0, -100, 2047);
        chk("e.rel3", int'(cl[0][2]), 1);
        vs(0, 0, -100, 2047);
        chk("e.rel4", int'(cl[0][2]), 0);
        cyc(1'b0, 0, 0, 0, 0, 4'b0100, 4'b0000);
        chk("e.force_same", int'(cg[0][2]), 0);
        cyc(1'b0, 0, 0, 0, 0, 4'b0001, 4'b0001);
        chk("e.force_noval", int'(cl[0][0]), 1);
        cyc(1'b0, 0, 0, 0, 0, 4'b0001, 4'b0000);
        chk("e.force_open", int'(cg[0][0]), 1);

        // Reset in the middle of ch3 opening
        vs(0, 0, 0, -100); vs(0, 0, 0, -100);
        chk("e.ch3_pend", int'(bz[0]), 1);
        do_reset("rst1");
        vs(0, 0, 0, 100); vs(0, 0, 0, 100); vs(0, 0, 0, 100);
        chk("e.restart3", int'(cl[0][3]), 0);
        vs(0, 0, 0, 100);
        chk("e.restart4", int'(cl[0][3]), 1);

        // Toggle relay on u2 ch0
        do_reset("rst2");
        vs(0, 0, 0, 0); vs(100, 0, 0, 0);
        chk("f.pend", int'(bz[2]), 1);
        chk("f.pend_open", int'(cl[2][0]), 0);
        vs(100, 0, 0, 0);
        chk("f.tog1", int'(cl[2][0]), 1);
        chk("f.tog1_chg", int'(cg[2][0]), 1);
        for (int n = 0; n < 3; n++) vs(100, 0, 0, 0);
        chk("f.held", int'(cl[2][0]), 1);
        vs(0, 0, 0, 0); vs(100, 0, 0, 0); vs(100, 0, 0, 0);
        chk("f.tog0", int'(cl[2][0]), 0);
        chk("f.tog0_chg", int'(cg[2][0]), 1);
        vs(0, 0, 0, 0); vs(100, 0, 0, 0); vs(0, 0, 0, 0); vs(100, 0, 0, 0);
        chk("f.broken", int'(cl[2][0]), 0);

        // All channels switch together
        do_reset("rst3");
        for (int n = 0; n < 4; n++) vs(100, 100, 100, 100);
        chk("g.all_closed", int'(cl[0]), 15);
        chk("g.all_change", int'(cg[0]), 15);
        for (int n = 0; n < 4; n++) vs(-100, -100, -100, -100);
        chk("g.all_open", int'(cl[0]), 0);
        gap();

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/relais_bank.md
RELAIS_BANK -- requirements
Module: relais_bank

Interface
REQ-001 SHALL have parameter CH, default 4, number of independent relay channels (1..16).
REQ-002 SHALL have parameter W, default 12, width of each signed control sample.
REQ-003 SHALL have parameter VT, default 0, signed switching threshold code common to all channels.
REQ-004 SHALL have parameter VH, default 64, non-negative hysteresis half-width code.
REQ-005 SHALL have parameter DEB, default 4, consecutive qualifying samples required to switch (1..255).
REQ-006 SHALL have parameter LATCH, default 0: 0 = hysteresis relay, 1 = latching (toggle) relay.
REQ-007 clk  input  1  sole clock; all state updates on rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 in_valid  input  1  in_data holds a new sample set this cycle.
REQ-010 in_data  input  CH*W  channel k sample at bits [k*W +: W], two's complement.
REQ-011 force_en  input  CH  per-channel override request.
REQ-012 force_val  input  CH  override contact value (1 = closed).
REQ-013 closed  output  CH  registered contact state per channel.
REQ-014 change  output  CH  one-cycle pulse, high in the cycle closed[k] takes a new value.
REQ-015 busy  output  1  high while any channel is in a pending state.

Function
REQ-016 Each channel SHALL run a 4-state FSM: OPEN, PEND_CLOSE, CLOSED, PEND_OPEN, plus a debounce counter of clog2(DEB+1) bits.
REQ-017 Thresholds SHALL be computed as TH_HI = VT+VH and TH_LO = VT-VH in W+1-bit signed arithmetic; samples sign-extended to W+1 bits; no wrap.
REQ-018 Qualify-close (LATCH=0): sample > TH_HI strictly; qualify-open: sample < TH_LO strictly; equality qualifies neither.
REQ-019 LATCH=1: qualify-toggle = sample > TH_HI in a valid sample following a valid sample <= TH_HI for that channel (edge); state toggles after DEB consecutive qualifying valid samples > TH_HI counted from the edge.
REQ-020 Counter SHALL advance only in cycles with in_valid=1; cycles with in_valid=0 hold state and counter.
REQ-021 OPEN: qualify-close valid sample -> PEND_CLOSE, counter=1; if DEB=1 go directly to CLOSED.
REQ-022 PEND_CLOSE: qualifying valid sample increments counter; on reaching DEB -> CLOSED; non-qualifying valid sample -> OPEN, counter=0.
REQ-023 CLOSED/PEND_OPEN SHALL mirror REQ-021/022 with qualify-open.
REQ-024 closed[k] SHALL be 1 exactly in CLOSED and PEND_OPEN; update latency: one clk after the DEB-th qualifying sample edge.
REQ-025 change[k] SHALL pulse in the same cycle closed[k] updates, never otherwise.
REQ-026 force_en[k]=1 SHALL override: next cycle state = CLOSED if force_val[k] else OPEN, counter=0, regardless of in_valid; change pulses only if closed[k] differs.
REQ-027 force_en held high SHALL keep the channel pinned; debounce restarts from the pinned state after release.
REQ-028 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL all be honoured in the same cycle.
REQ-029 busy = OR over channels of (state in PEND_CLOSE or PEND_OPEN), registered.

Reset
REQ-030 rst_n low SHALL immediately (asynchronously) force all channels to OPEN, counters 0, closed=0, change=0, busy=0, LATCH edge history = "below".
REQ-031 Reset asserted mid-debounce SHALL discard partial counts; first valid sample after release starts from OPEN.
REQ-032 Release of rst_n SHALL be treated synchronously; first state update on the first rising clk with rst_n high.

Verification
REQ-033 Defaults, ch0 samples 100 with in_valid=1 for 4 cycles -> closed[0]=1 and change[0] pulse one clk after 4th sample; busy high cycles 1-4.
REQ-034 Ch0 closed, samples -30 (inside band, above TH_LO=-64) indefinitely -> closed[0] stays 1; then -65 x4 -> closed[0]=0 with one change pulse.
REQ-035 Ch1 samples 100,100,100,0,100 -> no close; counter restarts, closes only after 4 further samples of 100; gaps with in_valid=0 inserted -> same result.
REQ-036 Sample exactly 64 (=TH_HI) repeated 10 times -> no transition; W=12, VT=2047, VH=64: sample 2047 never closes (no overflow wrap).
REQ-037 force_en[2]=1, force_val[2]=1 while ch2 in PEND_CLOSE -> closed[2]=1 next cycle, counter 0; rst_n pulsed low mid-count on ch3 -> all outputs 0 immediately, no change pulse.
REQ-038 LATCH=1, DEB=2: ch0 samples 0,100,100 -> closed toggles to 1; 100 held -> no further toggle; 0,100,100 -> toggles to 0.
